// File: rtl/fifo_ext.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags,
// sticky error flags and selectable FWFT / registered read.
module fifo_ext #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_WIDTH = 32,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr,
  input  logic                            rd,
  input  logic [FIFO_WIDTH-1:0]           w_data,
  output logic [FIFO_WIDTH-1:0]           r_data,
  output logic                            r_valid,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            overflow,
  output logic                            underflow,
  input  logic                            clr_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef logic [PW-1:0] ptr_t;

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_ext: FIFO_DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
    $fatal(1, "fifo_ext: AF_LEVEL out of range");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_ext: AE_LEVEL out of range");
  end

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  ptr_t          w_ptr;
  ptr_t          r_ptr;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic          full_q;
  logic          empty_q;
  logic          af_q;
  logic          ae_q;
  logic          ovf_q;
  logic          udf_q;
  logic          wr_acc;
  logic          rd_acc;

  // Explicit wrap so non-power-of-two depths never overrun the array.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_acc  = rd & ~empty_q;
    wr_acc  = wr & (~full_q | rd_acc);
    cnt_nxt = cnt_q;
    unique case (1'b1)
      wr_acc & ~rd_acc: cnt_nxt = cnt_q + 1'b1;
      rd_acc & ~wr_acc: cnt_nxt = cnt_q - 1'b1;
      default:          cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= (AF_LEVEL == 0);
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= ptr_inc(w_ptr);
      if (rd_acc) r_ptr <= ptr_inc(r_ptr);
      cnt_q   <= cnt_nxt;
      full_q  <= (cnt_nxt == CW'(FIFO_DEPTH));
      empty_q <= (cnt_nxt == '0);
      af_q    <= (cnt_nxt >= CW'(AF_LEVEL));
      ae_q    <= (cnt_nxt <= CW'(AE_LEVEL));
      // A fresh error outranks a simultaneous clear.
      ovf_q   <= (wr & ~wr_acc) | (ovf_q & ~clr_err);
      udf_q   <= (rd & empty_q) | (udf_q & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr] <= w_data;
  end

  if (FWFT != 0) begin : g_fwft
    // Gate with empty so stale storage never leaks after reset.
    assign r_data  = empty_q ? '0 : mem[r_ptr];
    assign r_valid = ~empty_q;
  end else begin : g_reg
    logic [FIFO_WIDTH-1:0] rdat_q;
    logic                  rv_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rdat_q <= '0;
        rv_q   <= 1'b0;
      end else begin
        rv_q <= rd_acc;
        if (rd_acc) rdat_q <= mem[r_ptr];
      end
    end

    assign r_data  = rdat_q;
    assign r_valid = rv_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ext.sv
// Bench for fifo_ext: FWFT and registered-read instances share stimulus,
// checked against a queue model with scoreboard monitors.
module tb_fifo_ext;

  localparam int D  = 5;
  localparam int W  = 8;
  localparam int AF = 3;
  localparam int AE = 2;
  localparam int CW = $clog2(D + 1);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr = 1'b0;
  logic         rd = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] w_data = '0;

  logic [W-1:0]  r_data_f, r_data_r;
  logic          r_valid_f, r_valid_r;
  logic          full_f, full_r, empty_f, empty_r;
  logic          af_f, af_r, ae_f, ae_r;
  logic [CW-1:0] cnt_f, cnt_r;
  logic          ovf_f, ovf_r, udf_f, udf_r;

  fifo_ext #(
    .FIFO_DEPTH(D), .FIFO_WIDTH(W), .AF_LEVEL(AF),
    .AE_LEVEL(AE), .FWFT(1)
  ) u_fwft (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd),
    .w_data(w_data), .r_data(r_data_f), .r_valid(r_valid_f),
    .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f),
    .count(cnt_f), .overflow(ovf_f), .underflow(udf_f),
    .clr_err(clr_err)
  );

  fifo_ext #(
    .FIFO_DEPTH(D), .FIFO_WIDTH(W), .AF_LEVEL(AF),
    .AE_LEVEL(AE), .FWFT(0)
  ) u_reg (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd),
    .w_data(w_data), .r_data(r_data_r), .r_valid(r_valid_r),
    .full(full_r), .empty(empty_r),
    .almost_full(af_r), .almost_empty(ae_r),
    .count(cnt_r), .overflow(ovf_r), .underflow(udf_r),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] exp_f[$];
  logic [W-1:0] exp_r[$];
  bit           ovf_m = 1'b0;
  bit           udf_m = 1'b0;
  bit           rv_m  = 1'b0;
  logic [W-1:0] last_m = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int c;
    c = mq.size();
    chk("count_f", 32'(cnt_f), 32'(c));
    chk("count_r", 32'(cnt_r), 32'(c));
    chk("full_f", 32'(full_f), 32'(c == D));
    chk("full_r", 32'(full_r), 32'(c == D));
    chk("empty_f", 32'(empty_f), 32'(c == 0));
    chk("empty_r", 32'(empty_r), 32'(c == 0));
    chk("almost_full", 32'(af_f), 32'(c >= AF));
    chk("almost_empty", 32'(ae_f), 32'(c <= AE));
    chk("overflow_f", 32'(ovf_f), 32'(ovf_m));
    chk("overflow_r", 32'(ovf_r), 32'(ovf_m));
    chk("underflow_f", 32'(udf_f), 32'(udf_m));
    chk("underflow_r", 32'(udf_r), 32'(udf_m));
    chk("r_valid_f", 32'(r_valid_f), 32'(c != 0));
    chk("r_valid_r", 32'(r_valid_r), 32'(rv_m));
    if (!rv_m) chk("r_data_hold", 32'(r_data_r), 32'(last_m));
  endtask

  task automatic check_reset_vals();
    chk("rst_count", 32'(cnt_f), 32'(0));
    chk("rst_empty", 32'(empty_f), 32'(1));
    chk("rst_full", 32'(full_f), 32'(0));
    chk("rst_af", 32'(af_f), 32'(0));
    chk("rst_ae", 32'(ae_f), 32'(1));
    chk("rst_ovf", 32'(ovf_f), 32'(0));
    chk("rst_udf", 32'(udf_f), 32'(0));
    chk("rst_rvalid_f", 32'(r_valid_f), 32'(0));
    chk("rst_rvalid_r", 32'(r_valid_r), 32'(0));
    chk("rst_rdata_f", 32'(r_data_f), 32'(0));
    chk("rst_rdata_r", 32'(r_data_r), 32'(0));
    chk("rst_count_r", 32'(cnt_r), 32'(0));
  endtask

  task automatic step(input bit w, input bit r,
                      input logic [W-1:0] d, input bit c);
    bit was_empty, rok, wok;
    logic [W-1:0] v;
    @(negedge clk);
    #1;
    check_state();
    wr = w; rd = r; w_data = d; clr_err = c;
    was_empty = (mq.size() == 0);
    rok = r && !was_empty;
    wok = w && (mq.size() < D || rok);
    if (rok) begin
      v = mq.pop_front();
      exp_f.push_back(v);
      exp_r.push_back(v);
      last_m = v;
    end
    rv_m = rok;
    if (wok) mq.push_back(d);
    ovf_m = (w && !wok) || (ovf_m && !c);
    udf_m = (r && was_empty) || (udf_m && !c);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    check_state();
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_vals();
    mq.delete(); exp_f.delete(); exp_r.delete();
    ovf_m = 1'b0; udf_m = 1'b0; rv_m = 1'b0; last_m = '0;
    @(negedge clk);
    #3 reset = 1'b1;
  endtask

  // Scoreboard monitors: FWFT pops on an accepted read, registered on r_valid.
  always @(negedge clk) begin
    #2;
    if (reset && rd && r_valid_f) begin
      if (exp_f.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL fwft_data: got %0h expected none", r_data_f);
      end else chk("fwft_data", 32'(r_data_f), 32'(exp_f.pop_front()));
    end
    if (reset && r_valid_r) begin
      if (exp_r.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL reg_data: got %0h expected none", r_data_r);
      end else chk("reg_data", 32'(r_data_r), 32'(exp_r.pop_front()));
    end
  end

  initial begin
    int pw;
    #2 reset = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    #3 reset = 1'b1;

    for (int i = 0; i < D; i++) step(1, 0, W'(8'hA0 + i), 0);
    step(1, 0, 8'hA5, 0);
    for (int i = 0; i < D; i++) step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(0, 0, '0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, W'(8'hB0 + i), 0);
    for (int i = 0; i < 3; i++) step(0, 1, '0, 0);

    for (int i = 0; i < D; i++) step(1, 0, W'(8'hC0 + i), 0);
    for (int i = 0; i < 3; i++) step(1, 1, W'(8'hD0 + i), 0);
    for (int i = 0; i < D; i++) step(0, 1, '0, 0);

    step(1, 1, 8'hE0, 0);
    step(0, 1, '0, 0);
    step(0, 0, '0, 1);

    step(0, 1, '0, 0);
    repeat (10) step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    for (int i = 0; i < D; i++) step(1, 0, W'(8'hF0 + i), 0);
    step(1, 0, 8'hFF, 1);
    step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    for (int i = 0; i < D; i++) step(0, 1, '0, 0);

    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    step(0, 1, '0, 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    step(0, 1, '0, 0);
    step(0, 0, '0, 0);

    for (int i = 0; i < 400; i++) begin
      pw = ((i / 40) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 50,
           W'($urandom), $urandom_range(0, 19) == 0);
    end

    repeat (D + 1) step(0, 1, '0, 0);
    step(0, 0, '0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, W'(8'h70 + i), 0);
    mid_reset();
    repeat (3) step(0, 0, '0, 0);
    step(1, 0, 8'h5A, 0);
    step(0, 1, '0, 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);

    @(negedge clk);
    #3;
    chk("fwft_drained", 32'(exp_f.size()), 32'(0));
    chk("reg_drained", 32'(exp_r.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
